// File: rtl/sub_shift_rows_seq.sv
// rtl/sub_shift_rows_seq.sv - AES SubBytes+ShiftRows, one column per cycle over four S-box lanes
// Optional inverse mode (INV port, InvSubBytes+InvShiftRows) is built when SSR_INV_EN is defined.
module sub_shift_rows_seq (
  input  logic         CLK,
  input  logic         RST,
  input  logic [0:127] ST_I,
  input  logic         IN_VALID,
  output logic         IN_READY,
  output logic [0:127] ST_O,
  output logic         OUT_VALID,
  input  logic         OUT_READY
`ifdef SSR_INV_EN
  ,
  input  logic         INV
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Each table row holds 16 consecutive entries, leftmost byte = low nibble 0.
  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [0:127] row;
    case (x[7:4])
      4'h0:    row = 128'h637c777bf26b6fc53001672bfed7ab76;
      4'h1:    row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
      4'h2:    row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
      4'h3:    row = 128'h04c723c31896059a071280e2eb27b275;
      4'h4:    row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
      4'h5:    row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
      4'h6:    row = 128'hd0efaafb434d338545f9027f503c9fa8;
      4'h7:    row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
      4'h8:    row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
      4'h9:    row = 128'h60814fdc222a908846eeb814de5e0bdb;
      4'ha:    row = 128'he0323a0a4906245cc2d3ac629195e479;
      4'hb:    row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
      4'hc:    row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
      4'hd:    row = 128'h703eb5664803f60e613557b986c11d9e;
      4'he:    row = 128'he1f8981169d98e949b1e87e9ce5528df;
      default: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
    endcase
    return row[{x[3:0], 3'b000} +: 8];
  endfunction

`ifdef SSR_INV_EN
  function automatic logic [7:0] sbox_inv(input logic [7:0] x);
    logic [0:127] row;
    case (x[7:4])
      4'h0:    row = 128'h52096ad53036a538bf40a39e81f3d7fb;
      4'h1:    row = 128'h7ce339829b2fff87348e4344c4dee9cb;
      4'h2:    row = 128'h547b9432a6c2233dee4c950b42fac34e;
      4'h3:    row = 128'h082ea16628d924b2765ba2496d8bd125;
      4'h4:    row = 128'h72f8f66486689816d4a45ccc5d65b692;
      4'h5:    row = 128'h6c704850fdedb9da5e154657a78d9d84;
      4'h6:    row = 128'h90d8ab008cbcd30af7e45805b8b34506;
      4'h7:    row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
      4'h8:    row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
      4'h9:    row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
      4'ha:    row = 128'h47f11a711d29c5896fb7620eaa18be1b;
      4'hb:    row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
      4'hc:    row = 128'h1fdda8338807c731b11210592780ec5f;
      4'hd:    row = 128'h60517fa919b54a0d2de57a9f93c99cef;
      4'he:    row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
      default: row = 128'h172b047eba77d626e169146355210c7d;
    endcase
    return row[{x[3:0], 3'b000} +: 8];
  endfunction
`endif

  logic [1:0]       state_q, state_d;
  logic [0:127]     in_q, in_d;
  logic [1:0]       col_q, col_d;
  logic [0:127]     st_o_q, st_o_d;
  logic [1:0]       fwd_c;
  logic [3:0][7:0]  sb_out;
`ifdef SSR_INV_EN
  logic             inv_q, inv_d;
  logic [1:0]       inv_c;
`endif

  // Lane r produces row r of the current output column; the source column is rotated by r.
  always_comb begin
    fwd_c  = '0;
    sb_out = '0;
`ifdef SSR_INV_EN
    inv_c  = '0;
`endif
    for (int r = 0; r < 4; r++) begin
      fwd_c     = col_q + 2'(r);
      sb_out[r] = sbox_fwd(in_q[{fwd_c, 2'(r), 3'b000} +: 8]);
`ifdef SSR_INV_EN
      inv_c = col_q - 2'(r);
      if (inv_q) begin
        sb_out[r] = sbox_inv(in_q[{inv_c, 2'(r), 3'b000} +: 8]);
      end
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    in_d    = in_q;
    col_d   = col_q;
    st_o_d  = st_o_q;
`ifdef SSR_INV_EN
    inv_d   = inv_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (IN_VALID) begin
          in_d    = ST_I;
          col_d   = 2'd0;
          state_d = ST_BUSY;
`ifdef SSR_INV_EN
          inv_d   = INV;
`endif
        end
      end
      ST_BUSY: begin
        for (int r = 0; r < 4; r++) begin
          st_o_d[{col_q, 2'(r), 3'b000} +: 8] = sb_out[r];
        end
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (OUT_READY) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      in_q    <= '0;
      col_q   <= '0;
      st_o_q  <= '0;
`ifdef SSR_INV_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      col_q   <= col_d;
      st_o_q  <= st_o_d;
`ifdef SSR_INV_EN
      inv_q   <= inv_d;
`endif
    end
  end

  assign IN_READY  = (state_q == ST_IDLE);
  assign OUT_VALID = (state_q == ST_DONE);
  assign ST_O      = st_o_q;

endmodule

// File: tb/tb_sub_shift_rows_seq.sv
// tb/tb_sub_shift_rows_seq.sv - randomized bench with a GF(2^8)-derived AES reference model
module tb_sub_shift_rows_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [0:127] st_i = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [0:127] st_o;
  logic         out_valid;
  logic         out_ready = 1'b0;
`ifdef SSR_INV_EN
  logic         inv = 1'b0;
`endif

  sub_shift_rows_seq dut (
    .CLK       (clk),
    .RST       (rst),
    .ST_I      (st_i),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .ST_O      (st_o),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready)
`ifdef SSR_INV_EN
    ,
    .INV       (inv)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0] fsb [256];
  logic [7:0] isb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from first principles: multiplicative inverse followed by the affine map.
  task automatic build_tables();
    logic [7:0] inv_b, s;
    for (int a = 0; a < 256; a++) begin
      inv_b = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(a), 8'(b)) == 8'h01) inv_b = 8'(b);
      end
      s = inv_b ^ rotl(inv_b, 1) ^ rotl(inv_b, 2) ^ rotl(inv_b, 3) ^ rotl(inv_b, 4) ^ 8'h63;
      fsb[a] = s;
      isb[s] = 8'(a);
    end
  endtask

  function automatic logic [0:127] expect_out(input logic [0:127] v, input logic m);
    logic [0:127] o;
    logic [7:0]   b;
    int           src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = m ? ((c - r + 4) % 4) : ((c + r) % 4);
        b = v[8*(4*src + r) +: 8];
        o[8*(4*c + r) +: 8] = m ? isb[b] : fsb[b];
      end
    end
    return o;
  endfunction

  function automatic logic [0:127] mixcol(input logic [0:127] v);
    logic [0:127] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = v[8*(4*c)+:8]; a1 = v[8*(4*c+1)+:8]; a2 = v[8*(4*c+2)+:8]; a3 = v[8*(4*c+3)+:8];
      o[8*(4*c)  +:8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      o[8*(4*c+1)+:8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      o[8*(4*c+2)+:8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      o[8*(4*c+3)+:8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [0:127] act, input logic [0:127] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: a state becomes visible 4 edges after acceptance and leaves on the handshake edge.
  int           cyc = 0;
  bit           pending = 1'b0;
  int           acc_edge = 0;
  logic [0:127] exp_data = '0;
  bit           chk_en = 1'b0;
  bit           after_rst = 1'b0;
  int           n_acc = 0;
  int           n_xfer = 0;
  int           acc_edges [$];
  logic [0:127] last_out = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    bit ev;
    ev = pending && (cyc >= acc_edge + 4);
    if (chk_en) begin
      check("in_ready", in_ready, !pending);
      check("out_valid", out_valid, ev);
      if (ev) check("st_o", st_o, exp_data);
      if (after_rst) check("st_o_after_reset", st_o, '0);
    end
    after_rst = rst;
    if (rst) begin
      pending = 1'b0;
      chk_en  = 1'b1;
    end else if (!pending && in_valid) begin
      pending  = 1'b1;
      acc_edge = cyc + 1;
`ifdef SSR_INV_EN
      exp_data = expect_out(st_i, inv);
`else
      exp_data = expect_out(st_i, 1'b0);
`endif
      n_acc++;
      acc_edges.push_back(cyc + 1);
    end else if (ev && out_ready) begin
      pending  = 1'b0;
      last_out = st_o;
      n_xfer++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [0:127] d);
    int target, k;
    target   = n_acc + 1;
    k        = 0;
    st_i     = d;
    in_valid = 1'b1;
    while (n_acc < target && k < 50) begin
      step();
      k++;
    end
    in_valid = 1'b0;
    total++;
    if (n_acc < target) begin
      bad++;
      $display("FAIL accept_timeout: accepted %0d want %0d", n_acc, target);
    end
  endtask

  task automatic wait_xfer(input int n, input string nm);
    int k;
    k = 0;
    while (n_xfer < n && k < 100) begin
      step();
      k++;
    end
    total++;
    if (n_xfer < n) begin
      bad++;
      $display("FAIL %s_timeout: transfers %0d want %0d", nm, n_xfer, n);
    end
  endtask

  function automatic logic [0:127] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int k, a0;
    build_tables();
    repeat (2) step();
    rst = 1'b0;
    step();

    out_ready = 1'b1;
    send('0);
    wait_xfer(n_xfer + 1, "zero");
    check("zero_vector", last_out, {16{8'h63}});

    send(128'h193de3bea0f4e22b9ac68d2ae9f84808);
    wait_xfer(n_xfer + 1, "fips");
    check("fips_ssr", last_out, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
    check("fips_mixcol", mixcol(last_out), 128'h046681e5e0cb199a48f8d37a2806264c);

    // Backpressure with stray IN_VALID pulses while the result is held.
    out_ready = 1'b0;
    send(rnd128());
    k = 0;
    while (!out_valid && k < 20) begin
      step();
      k++;
    end
    check("bp_reached_valid", out_valid, 1'b1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      st_i     = rnd128();
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_xfer(n_xfer + 1, "bp");

    // Reset sampled at the second edge after acceptance.
    send(rnd128());
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    send(rnd128());
    wait_xfer(n_xfer + 1, "post_reset");

    a0 = acc_edges.size();
    k  = n_xfer;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && n_acc < a0 + 3; i++) begin
      st_i = rnd128();
      step();
    end
    in_valid = 1'b0;
    wait_xfer(k + 3, "b2b");
    if (acc_edges.size() >= a0 + 3) begin
      check("b2b_gap0", 128'(acc_edges[a0 + 1] - acc_edges[a0]), 128'd6);
      check("b2b_gap1", 128'(acc_edges[a0 + 2] - acc_edges[a0 + 1]), 128'd6);
    end else begin
      check("b2b_accept_count", 128'(acc_edges.size() - a0), 128'd3);
    end

`ifdef SSR_INV_EN
    inv = 1'b1;
    send(128'hd4bf5d30e0b452aeb84111f11e2798e5);
    inv = 1'b0;
    step();
    inv = 1'b1;
    step();
    inv = 1'b0;
    wait_xfer(n_xfer + 1, "inv");
    check("inv_vector", last_out, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    inv = 1'b0;
    send(128'h193de3bea0f4e22b9ac68d2ae9f84808);
    inv = 1'b1;
    wait_xfer(n_xfer + 1, "inv0");
    check("inv0_vector", last_out, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
`endif

    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      st_i      = rnd128();
`ifdef SSR_INV_EN
      inv       = 1'($urandom_range(0, 1));
`endif
      step();
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
